// File: rtl/fma_pkg.sv
// Shared FMA-array constants, lane operation modes and arbiter state encoding.
package fma_pkg;

    localparam int BW_EXP          = 8;
    localparam int BW_MAN          = 9;
    localparam int BW_FP           = BW_EXP + BW_MAN;
    localparam int VALUE_MN        = 64;
    localparam int MODE_W          = 5;
    localparam int FMA_LAT_DEFAULT = 2;

    // Only IDLE and MUL are defined; the remaining codes are reserved.
    typedef enum logic [MODE_W-1:0] {
        IDLE = 5'b00000,
        MUL  = 5'b00010
    } fma_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_CLIENT = 4,
    parameter int ID_W       = 2
) (
    input  logic [NUM_CLIENT-1:0] req,
    input  logic [ID_W-1:0]       ptr,
    output logic [NUM_CLIENT-1:0] grant,
    output logic [ID_W-1:0]       grant_id
);

    function automatic int wrap_idx(input int i);
        return (i >= NUM_CLIENT) ? i - NUM_CLIENT : i;
    endfunction

    // Scan from the farthest candidate back toward ptr so the closest
    // requester overwrites any earlier pick and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that leaves
        // a combinational output unassigned would infer a latch.
        grant    = '0;
        grant_id = '0;
        for (int k = NUM_CLIENT - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr) + k)]) begin
                grant                            = '0;
                grant[wrap_idx(int'(ptr) + k)]   = 1'b1;
                grant_id                         = ID_W'(wrap_idx(int'(ptr) + k));
            end
        end
    end

endmodule

// File: rtl/fma_share_arb.sv
// Shares one FMA array between NUM_CLIENT controllers: round-robin grant with
// optional lock, registered operand issue, and a tag pipeline routing results back.
module fma_share_arb #(
    parameter int NUM_CLIENT = 4,
    parameter int VALUE_MN   = fma_pkg::VALUE_MN,
    parameter int BW_FP      = fma_pkg::BW_FP,
    parameter int FMA_LAT    = fma_pkg::FMA_LAT_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_CLIENT-1:0]                   req_valid,
    input  logic [NUM_CLIENT-1:0]                   req_lock,
    input  logic [NUM_CLIENT*VALUE_MN*5-1:0]        req_mode,
    input  logic [NUM_CLIENT*VALUE_MN*BW_FP-1:0]    req_a,
    input  logic [NUM_CLIENT*VALUE_MN*BW_FP-1:0]    req_b,
    output logic [NUM_CLIENT-1:0]                   req_ready,
    output logic [VALUE_MN*5-1:0]                   fma_mode,
    output logic [VALUE_MN*BW_FP-1:0]               fma_a,
    output logic [VALUE_MN*BW_FP-1:0]               fma_b,
    input  logic [VALUE_MN*BW_FP-1:0]               fma_out,
    output logic [NUM_CLIENT-1:0]                   rsp_valid,
    output logic [VALUE_MN*BW_FP-1:0]               rsp_data,
    output logic                                    arb_busy
);

    localparam int ID_W    = $clog2(NUM_CLIENT);
    localparam int MODE_VW = VALUE_MN * fma_pkg::MODE_W;
    localparam int DATA_VW = VALUE_MN * BW_FP;
    localparam int N_STAGE = FMA_LAT + 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    fma_pkg::arb_state_e          state_q, state_d;
    logic [ID_W-1:0]              owner_q, owner_d;
    logic [ID_W-1:0]              ptr_q, ptr_d;
    tag_t [N_STAGE-1:0]           tag_q, tag_d;
    logic [MODE_VW-1:0]           fma_mode_q, fma_mode_d;
    logic [DATA_VW-1:0]           fma_a_q, fma_a_d;
    logic [DATA_VW-1:0]           fma_b_q, fma_b_d;
    logic [NUM_CLIENT-1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_VW-1:0]           rsp_data_q, rsp_data_d;

    logic [NUM_CLIENT-1:0]        rr_grant;
    logic [ID_W-1:0]              rr_id;
    logic [NUM_CLIENT-1:0]        grant_oh;
    logic [ID_W-1:0]              grant_id;
    logic                         accept;

    rr_arbiter #(
        .NUM_CLIENT (NUM_CLIENT),
        .ID_W       (ID_W)
    ) u_rr (
        .req      (req_valid),
        .ptr      (ptr_q),
        .grant    (rr_grant),
        .grant_id (rr_id)
    );

    always_comb begin
        grant_oh = rr_grant;
        grant_id = rr_id;
        if (state_q == fma_pkg::ST_LOCKED) begin
            grant_oh = (NUM_CLIENT'(1) << owner_q) & req_valid;
            grant_id = owner_q;
        end
        accept = |grant_oh;

        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        fma_mode_d = {VALUE_MN{fma_pkg::IDLE}};
        fma_a_d    = '0;
        fma_b_d    = '0;

        // Updating ptr on every accept is safe while locked: the owner is
        // the only grantee, so the value written never changes until unlock.
        if (accept) begin
            state_d    = req_lock[grant_id] ? fma_pkg::ST_LOCKED : fma_pkg::ST_IDLE;
            owner_d    = grant_id;
            ptr_d      = (grant_id == ID_W'(NUM_CLIENT - 1)) ? '0 : grant_id + 1'b1;
            fma_mode_d = req_mode[int'(grant_id) * MODE_VW +: MODE_VW];
            fma_a_d    = req_a[int'(grant_id) * DATA_VW +: DATA_VW];
            fma_b_d    = req_b[int'(grant_id) * DATA_VW +: DATA_VW];
        end

        tag_d[0].valid = accept;
        tag_d[0].id    = grant_id;
        for (int s = 1; s < N_STAGE; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_q[N_STAGE-1].valid) begin
            rsp_valid_d = NUM_CLIENT'(1) << tag_q[N_STAGE-1].id;
            rsp_data_d  = fma_out;
        end
    end

    always_comb begin
        arb_busy = (state_q == fma_pkg::ST_LOCKED);
        for (int s = 0; s < N_STAGE; s++) begin
            arb_busy = arb_busy | tag_q[s].valid;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= fma_pkg::ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            tag_q       <= '0;
            fma_mode_q  <= {VALUE_MN{fma_pkg::IDLE}};
            fma_a_q     <= '0;
            fma_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            tag_q       <= tag_d;
            fma_mode_q  <= fma_mode_d;
            fma_a_q     <= fma_a_d;
            fma_b_q     <= fma_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = grant_oh;
    assign fma_mode  = fma_mode_q;
    assign fma_a     = fma_a_q;
    assign fma_b     = fma_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fma_share_arb.sv
// Scoreboard bench for fma_share_arb: a grant model predicts each accept, the
// expected response is queued, and per-DUT monitors (FMA_LAT 2 and 4) check returns.
module tb_fma_share_arb;
    import fma_pkg::*;

    localparam int NC   = 4;
    localparam int LAT  = FMA_LAT_DEFAULT;
    localparam int LAT4 = 4;
    localparam int LW   = VALUE_MN * BW_FP;
    localparam int MW   = VALUE_MN * MODE_W;
    localparam logic [BW_FP-1:0] FP_ONE = 17'h0FE00;
    localparam logic [BW_FP-1:0] FP_TWO = 17'h10000;

    typedef struct {
        int            id;
        logic [LW-1:0] data;
        int            due;
    } exp_rsp_t;

    logic             clk;
    logic             rst = 1'b1;
    logic [NC-1:0]    req_valid = '0;
    logic [NC-1:0]    req_lock = '0;
    logic [NC*MW-1:0] req_mode = '0;
    logic [NC*LW-1:0] req_a = '0;
    logic [NC*LW-1:0] req_b = '0;
    logic [NC-1:0]    req_ready, req_ready4;
    logic [MW-1:0]    fma_mode, fma_mode4;
    logic [LW-1:0]    fma_a, fma_b, fma_a4, fma_b4;
    logic [LW-1:0]    fma_out = '0;
    logic [LW-1:0]    fma_out4 = '0;
    logic [NC-1:0]    rsp_valid, rsp_valid4;
    logic [LW-1:0]    rsp_data, rsp_data4;
    logic             arb_busy, arb_busy4;

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    exp_rsp_t      sb[$];
    exp_rsp_t      sb4[$];
    int            m_ptr = 0;
    int            m_owner = 0;
    bit            m_locked = 1'b0;
    logic [MW-1:0] exp_mode = '0;
    logic [LW-1:0] exp_a = '0;
    logic [LW-1:0] exp_b = '0;
    logic [NC-1:0] obs_ready;
    logic          obs_busy;
    bit            force_en = 1'b0;
    logic [LW-1:0] force_val = '0;
    logic [LW-1:0] hr [LAT+1];
    logic [LW-1:0] hr4 [LAT4+1];
    logic [LW-1:0] last_d = '0;
    logic [LW-1:0] last_d4 = '0;

    fma_share_arb #(.NUM_CLIENT(NC), .FMA_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
        .req_mode(req_mode), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .fma_mode(fma_mode), .fma_a(fma_a), .fma_b(fma_b), .fma_out(fma_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .arb_busy(arb_busy)
    );

    fma_share_arb #(.NUM_CLIENT(NC), .FMA_LAT(LAT4)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
        .req_mode(req_mode), .req_a(req_a), .req_b(req_b), .req_ready(req_ready4),
        .fma_mode(fma_mode4), .fma_a(fma_a4), .fma_b(fma_b4), .fma_out(fma_out4),
        .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .arb_busy(arb_busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input bit ok, input string got, input string want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %s, expected %s", name, cyc, got, want);
        end
    endtask

    // Stand-in for the FMA array: a fixed lane-wise scramble of the operands.
    function automatic logic [LW-1:0] arr_fn(input logic [LW-1:0] a, input logic [LW-1:0] b);
        if (force_en) return force_val;
        return a ^ {b[LW-2:0], b[LW-1]};
    endfunction

    function automatic logic [NC-1:0] onehot(input int g);
        logic [NC-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic int model_grant();
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NC; k++) begin
            if (req_valid[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
        end
        return -1;
    endfunction

    // Predicts this cycle's grant, checks it, and books the expected response.
    task automatic step();
        int       g;
        exp_rsp_t e;
        @(negedge clk);
        obs_ready = req_ready;
        obs_busy  = arb_busy;
        if (rst) begin
            sb.delete();
            sb4.delete();
            m_ptr    = 0;
            m_owner  = 0;
            m_locked = 1'b0;
            exp_mode = '0;
            exp_a    = '0;
            exp_b    = '0;
        end else begin
            g = model_grant();
            check("req_ready", req_ready === onehot(g),
                  $sformatf("%b", req_ready), $sformatf("%b", onehot(g)));
            check("req_ready_lat4", req_ready4 === onehot(g),
                  $sformatf("%b", req_ready4), $sformatf("%b", onehot(g)));
            check("arb_busy", arb_busy === (sb.size() > 0 || m_locked),
                  $sformatf("%b", arb_busy), $sformatf("%b", sb.size() > 0 || m_locked));
            check("arb_busy_lat4", arb_busy4 === (sb4.size() > 0 || m_locked),
                  $sformatf("%b", arb_busy4), $sformatf("%b", sb4.size() > 0 || m_locked));
            if (g >= 0) begin
                e.id   = g;
                e.data = arr_fn(req_a[g*LW +: LW], req_b[g*LW +: LW]);
                e.due  = cyc + LAT + 2;
                sb.push_back(e);
                e.due  = cyc + LAT4 + 2;
                sb4.push_back(e);
                exp_mode = req_mode[g*MW +: MW];
                exp_a    = req_a[g*LW +: LW];
                exp_b    = req_b[g*LW +: LW];
                m_ptr    = (g + 1) % NC;
                if (req_lock[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end else begin
                    m_locked = 1'b0;
                end
            end else begin
                exp_mode = '0;
                exp_a    = '0;
                exp_b    = '0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic rand_client(input int i);
        for (int l = 0; l < VALUE_MN; l++)
            req_mode[i*MW + l*MODE_W +: MODE_W] = ($urandom_range(0, 3) != 0) ? MUL : IDLE;
        for (int j = 0; j < LW; j += 32) begin
            req_a[i*LW + j +: 32] = $urandom;
            req_b[i*LW + j +: 32] = $urandom;
        end
    endtask

    task automatic rand_all();
        for (int i = 0; i < NC; i++) rand_client(i);
    endtask

    initial begin : mon_main
        bit       rst_edge;
        exp_rsp_t e;
        for (int s = 0; s <= LAT; s++) hr[s] = '0;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            #1;
            check("fma_issue", fma_mode === exp_mode && fma_a === exp_a && fma_b === exp_b,
                  $sformatf("mode=%h a=%h b=%h", fma_mode[31:0], fma_a[31:0], fma_b[31:0]),
                  $sformatf("mode=%h a=%h b=%h", exp_mode[31:0], exp_a[31:0], exp_b[31:0]));
            if (rst_edge) begin
                check("reset_outputs", rsp_valid === '0 && rsp_data === '0 && arb_busy === 1'b0,
                      $sformatf("rsp_valid=%b data=%h busy=%b", rsp_valid, rsp_data[63:0], arb_busy),
                      "all zero");
                last_d = '0;
            end else if (rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1'b0, $sformatf("rsp_valid=%b", rsp_valid), "no pulse");
                end else begin
                    e = sb.pop_front();
                    check("rsp_owner", rsp_valid === onehot(e.id),
                          $sformatf("%b", rsp_valid), $sformatf("%b", onehot(e.id)));
                    check("rsp_latency", cyc == e.due, $sformatf("cycle %0d", cyc), $sformatf("cycle %0d", e.due));
                    check("rsp_data", rsp_data === e.data,
                          $sformatf("%h", rsp_data[63:0]), $sformatf("%h", e.data[63:0]));
                    last_d = e.data;
                end
            end else begin
                check("rsp_hold", rsp_data === last_d,
                      $sformatf("%h", rsp_data[63:0]), $sformatf("%h", last_d[63:0]));
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    check("rsp_timeout", 1'b0, "no pulse", $sformatf("pulse for client %0d", sb[0].id));
                    void'(sb.pop_front());
                end
            end
            for (int s = LAT; s > 0; s--) hr[s] = hr[s-1];
            hr[0]   = arr_fn(fma_a, fma_b);
            fma_out = hr[LAT];
        end
    end

    initial begin : mon_lat4
        bit       rst_edge;
        exp_rsp_t e;
        for (int s = 0; s <= LAT4; s++) hr4[s] = '0;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            #1;
            if (rst_edge) begin
                check("reset_outputs_lat4", rsp_valid4 === '0 && rsp_data4 === '0 && fma_mode4 === '0,
                      $sformatf("rsp_valid=%b data=%h", rsp_valid4, rsp_data4[63:0]), "all zero");
                last_d4 = '0;
            end else if (rsp_valid4 !== '0) begin
                if (sb4.size() == 0) begin
                    check("rsp_unexpected_lat4", 1'b0, $sformatf("rsp_valid=%b", rsp_valid4), "no pulse");
                end else begin
                    e = sb4.pop_front();
                    check("rsp_owner_lat4", rsp_valid4 === onehot(e.id),
                          $sformatf("%b", rsp_valid4), $sformatf("%b", onehot(e.id)));
                    check("rsp_latency_lat4", cyc == e.due, $sformatf("cycle %0d", cyc), $sformatf("cycle %0d", e.due));
                    check("rsp_data_lat4", rsp_data4 === e.data,
                          $sformatf("%h", rsp_data4[63:0]), $sformatf("%h", e.data[63:0]));
                    last_d4 = e.data;
                end
            end else begin
                check("rsp_hold_lat4", rsp_data4 === last_d4,
                      $sformatf("%h", rsp_data4[63:0]), $sformatf("%h", last_d4[63:0]));
                if (sb4.size() > 0 && sb4[0].due <= cyc) begin
                    check("rsp_timeout_lat4", 1'b0, "no pulse", $sformatf("pulse for client %0d", sb4[0].id));
                    void'(sb4.pop_front());
                end
            end
            for (int s = LAT4; s > 0; s--) hr4[s] = hr4[s-1];
            hr4[0]   = arr_fn(fma_a4, fma_b4);
            fma_out4 = hr4[LAT4];
        end
    end

    initial begin : stim
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Round-robin: all clients request continuously, order 0,1,2,3,0,...
        for (int k = 0; k < 8; k++) begin
            rand_all();
            req_valid = '1;
            req_lock  = '0;
            step();
            check("rr_order", obs_ready === onehot(k % NC),
                  $sformatf("%b", obs_ready), $sformatf("%b", onehot(k % NC)));
        end
        req_valid = '0;
        repeat (5) step();

        // Single op from client 2: MUL, a = 1.0, b = 2.0, array answers 2.0.
        force_en  = 1'b1;
        force_val = {VALUE_MN{FP_TWO}};
        for (int l = 0; l < VALUE_MN; l++) begin
            req_mode[2*MW + l*MODE_W +: MODE_W] = MUL;
            req_a[2*LW + l*BW_FP +: BW_FP]      = FP_ONE;
            req_b[2*LW + l*BW_FP +: BW_FP]      = FP_TWO;
        end
        req_valid = 4'b0100;
        step();
        check("single_grant", obs_ready === 4'b0100, $sformatf("%b", obs_ready), "0100");
        req_valid = '0;
        repeat (6) step();
        force_en = 1'b0;

        // Lock: client 1 issues 3 beats while 0 and 3 request; their lock bits are ignored.
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            rand_all();
            req_lock = (k < 2) ? 4'b1011 : 4'b1001;
            step();
            check("lock_owner_only", obs_ready === 4'b0010, $sformatf("%b", obs_ready), "0010");
        end
        req_lock = '0;
        step();
        check("lock_next_grant", obs_ready === 4'b1000, $sformatf("%b", obs_ready), "1000");
        req_valid = '0;
        repeat (5) step();

        // Lock stall: owner drops req_valid, others are held off and the array idles.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        step();
        check("stall_lock_grant", obs_ready === 4'b0010, $sformatf("%b", obs_ready), "0010");
        req_valid = 4'b0101;
        req_lock  = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_no_grant", obs_ready === 4'b0000, $sformatf("%b", obs_ready), "0000");
            check("stall_busy", obs_busy === 1'b1, $sformatf("%b", obs_busy), "1");
        end
        req_valid = 4'b0111;
        req_lock  = 4'b0000;
        step();
        check("stall_unlock_beat", obs_ready === 4'b0010, $sformatf("%b", obs_ready), "0010");
        req_valid = '0;
        repeat (5) step();

        // Reset mid-flight: two ops in the pipe are dropped, pointer restarts at 0.
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = '1;
        step();
        check("post_reset_grant", obs_ready === 4'b0001, $sformatf("%b", obs_ready), "0001");
        req_valid = '0;
        repeat (8) step();

        // Random traffic with occasional locks and idle cycles.
        for (int k = 0; k < 300; k++) begin
            rand_all();
            req_valid = NC'($urandom) | NC'($urandom);
            if ($urandom_range(0, 7) == 0) req_valid = '0;
            req_lock = NC'($urandom) & NC'($urandom);
            step();
        end
        req_valid = '0;
        req_lock  = '0;
        repeat (12) step();

        check("drain_empty", sb.size() == 0 && sb4.size() == 0,
              $sformatf("%0d/%0d pending", sb.size(), sb4.size()), "0/0 pending");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
